// File: rtl/magnetron_sr_bank_pkg.sv
// Shared types and constants for the magnetron SR latch bank.
// State encoding puts q in bit 1 and hold in bit 0, so both outputs come straight from the state flops.
package magnetron_pkg;

  localparam int PRIO_RESET  = 0;
  localparam int PRIO_SET    = 1;
  localparam int PRIO_TOGGLE = 2;

  typedef enum logic [1:0] {
    OFF_FREE = 2'b00,
    ON_HOLD  = 2'b11,
    ON_FREE  = 2'b10,
    OFF_HOLD = 2'b01
  } ch_state_e;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/magnetron_sr_bank_if.sv
// Request/status bundle between the oven controller and the latch bank.
interface magnetron_sr_bank_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] set;
  logic [CHANNELS-1:0] reset;
  logic                force_off;
  logic [CHANNELS-1:0] q;
  logic [CHANNELS-1:0] hold;
  logic [CHANNELS-1:0] pending;

  modport master (output set, reset, force_off, input q, hold, pending);
  modport slave  (input set, reset, force_off, output q, hold, pending);

endinterface

// File: rtl/magnetron_sr_bank_channel.sv
// One latch channel: priority resolution, min on/off hold counter and a one-deep pending request.
module sr_hold_channel
  import magnetron_pkg::*;
#(
  parameter int PRIORITY = PRIO_RESET,
  parameter int MIN_ON   = 3,
  parameter int MIN_OFF  = 2,
  parameter int CW       = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic reset,
  input  logic force_off,
  output logic q,
  output logic hold,
  output logic pending
);

  ch_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pend_q, pend_d;
  logic           q_cur, q_nx, req_vld, req_val, do_flip;
  logic [CW-1:0]  cnt_dec;

  assign q_cur = state_q[1];

  always_comb begin
    req_vld = set | reset;
    if (set && reset) begin
      if (PRIORITY == PRIO_SET)         req_val = 1'b1;
      else if (PRIORITY == PRIO_TOGGLE) req_val = ~q_cur;
      else                              req_val = 1'b0;
    end else begin
      req_val = set;
    end

    cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    q_nx    = q_cur;
    cnt_d   = cnt_dec;
    pend_d  = pend_q;
    do_flip = 1'b0;

    if (force_off) begin
      // Channels already off keep counting down rather than restarting their off-hold.
      q_nx   = 1'b0;
      pend_d = 1'b0;
      if (q_cur) cnt_d = CW'(MIN_OFF);
    end else if (cnt_q != '0) begin
      if (req_vld) pend_d = (req_val != q_cur);
    end else begin
      // A fresh request at the expiry edge overrides whatever was buffered.
      do_flip = req_vld ? (req_val != q_cur) : pend_q;
      pend_d  = 1'b0;
      if (do_flip) begin
        q_nx  = ~q_cur;
        cnt_d = q_cur ? CW'(MIN_OFF) : CW'(MIN_ON);
      end
    end

    state_d = ch_state_e'({q_nx, cnt_d != '0});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF_FREE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  assign q       = state_q[1];
  assign hold    = state_q[0];
  assign pending = pend_q;

endmodule

// File: rtl/magnetron_sr_bank.sv
// Bank of independent hold-protected SR latches driving the magnetron and its auxiliaries.
// force_off is the only signal shared between channels.
module magnetron_sr_bank
  import magnetron_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PRIORITY = PRIO_RESET,
  parameter int MIN_ON   = 3,
  parameter int MIN_OFF  = 2
) (
  input logic               clk,
  input logic               rst,
  magnetron_sr_bank_if.slave bus
);

  localparam int CW = cnt_width(MIN_ON, MIN_OFF);

  logic [CHANNELS-1:0] q_w, hold_w, pend_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sr_hold_channel #(
      .PRIORITY (PRIORITY),
      .MIN_ON   (MIN_ON),
      .MIN_OFF  (MIN_OFF),
      .CW       (CW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .set       (bus.set[i]),
      .reset     (bus.reset[i]),
      .force_off (bus.force_off),
      .q         (q_w[i]),
      .hold      (hold_w[i]),
      .pending   (pend_w[i])
    );
  end

  assign bus.q       = q_w;
  assign bus.hold    = hold_w;
  assign bus.pending = pend_w;

endmodule

// File: tb/tb_magnetron_sr_bank.sv
// Directed-vector bench for magnetron_sr_bank: one instance per priority mode, common stimulus.
module tb_magnetron_sr_bank;

  typedef struct {
    logic [3:0] s;
    logic [3:0] r;
    logic       f;
    logic [3:0] q;
    logic [3:0] h;
    logic [3:0] p;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  magnetron_sr_bank_if #(.CHANNELS(4)) bus0 ();
  magnetron_sr_bank_if #(.CHANNELS(4)) bus1 ();
  magnetron_sr_bank_if #(.CHANNELS(4)) bus2 ();

  magnetron_sr_bank #(.CHANNELS(4), .PRIORITY(0), .MIN_ON(3), .MIN_OFF(2))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  magnetron_sr_bank #(.CHANNELS(4), .PRIORITY(1), .MIN_ON(3), .MIN_OFF(2))
    u1 (.clk(clk), .rst(rst), .bus(bus1));
  magnetron_sr_bank #(.CHANNELS(4), .PRIORITY(2), .MIN_ON(3), .MIN_OFF(2))
    u2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [3:0] r, input logic f);
    bus0.set = s; bus0.reset = r; bus0.force_off = f;
    bus1.set = s; bus1.reset = r; bus1.force_off = f;
    bus2.set = s; bus2.reset = r; bus2.force_off = f;
  endtask

  task automatic step(input logic [3:0] s, input logic [3:0] r, input logic f);
    @(negedge clk);
    drive(s, r, f);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] s, input logic [3:0] r, input logic f,
                     input logic [3:0] q, input logic [3:0] h, input logic [3:0] p);
    vec_t v;
    v.s = s; v.r = r; v.f = f; v.q = q; v.h = h; v.p = p;
    tbl.push_back(v);
  endtask

  initial begin
    //    set      reset    frc   q        hold     pending
    // basic latch on ch0
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000); // e1
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 4'b0000); // e6
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // reset buffered during on-hold, applied at expiry
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000); // e9
    add(4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0001);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000); // e13
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // cancelled pending on ch1
    add(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b0000); // e16
    add(4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0010, 4'b0010);
    add(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    // force_off with ch0 in on-hold holding a pending reset
    add(4'b0001, 4'b0000, 1'b0, 4'b0011, 4'b0001, 4'b0000); // e21
    add(4'b0000, 4'b0001, 1'b0, 4'b0011, 4'b0001, 4'b0001);
    add(4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0011, 4'b0000); // e23
    add(4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0011, 4'b0000);
    add(4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4'b0000); // e26
    add(4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'b0000);
    add(4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b1111, 4'b0000); // e30
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0000);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // short force: set after release waits for off-hold expiry
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000); // e33
    add(4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0001, 4'b0000);
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0001);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001, 4'b0000); // e37
    // all on, ch0 mid-hold with a pending reset, ready for async reset
    add(4'b1110, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    add(4'b0000, 4'b0001, 1'b0, 4'b1111, 4'b1111, 4'b0001); // e39

    drive(4'b0000, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("init q", bus0.q, 4'b0000);
    chk("init hold", bus0.hold, 4'b0000);
    chk("init pending", bus0.pending, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].r, tbl[i].f);
      chk($sformatf("e%0d q", i + 1), bus0.q, tbl[i].q);
      chk($sformatf("e%0d hold", i + 1), bus0.hold, tbl[i].h);
      chk($sformatf("e%0d pending", i + 1), bus0.pending, tbl[i].p);
    end

    // asynchronous reset between clock edges
    @(negedge clk);
    drive(4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    #1;
    chk("async rst q", bus0.q, 4'b0000);
    chk("async rst hold", bus0.hold, 4'b0000);
    chk("async rst pending", bus0.pending, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 4'b0000, 1'b0);
    chk("post rst q", bus0.q, 4'b0000);
    chk("post rst pending", bus0.pending, 4'b0000);

    // simultaneous set+reset per priority mode
    step(4'b0001, 4'b0001, 1'b0);
    chk("p1 rdom q", bus0.q, 4'b0000);
    chk("p1 rdom hold", bus0.hold, 4'b0000);
    chk("p1 sdom q", bus1.q, 4'b0001);
    chk("p1 sdom hold", bus1.hold, 4'b0001);
    chk("p1 tog q", bus2.q, 4'b0001);
    repeat (3) step(4'b0000, 4'b0000, 1'b0);
    chk("p4 tog hold", bus2.hold, 4'b0000);
    step(4'b0001, 4'b0001, 1'b0);
    chk("p5 tog q", bus2.q, 4'b0000);
    chk("p5 tog hold", bus2.hold, 4'b0001);
    chk("p5 sdom q", bus1.q, 4'b0001);
    chk("p5 rdom q", bus0.q, 4'b0000);
    step(4'b0001, 4'b0001, 1'b0);
    chk("p6 tog q", bus2.q, 4'b0000);
    chk("p6 tog pending", bus2.pending, 4'b0001);
    step(4'b0000, 4'b0000, 1'b0);
    chk("p7 tog hold", bus2.hold, 4'b0000);
    chk("p7 tog pending", bus2.pending, 4'b0001);
    step(4'b0000, 4'b0000, 1'b0);
    chk("p8 tog q", bus2.q, 4'b0001);
    chk("p8 tog pending", bus2.pending, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/magnetron_sr_bank.md
# magnetron_sr_bank

Parametrised, clocked bank of SR latches that drives the magnetron enable lines and their auxiliaries (fan, lamp, turntable) from the controller's set/reset pulses. Each channel has a configurable simultaneous-input priority mode. Each channel also enforces a minimum on-time and a minimum off-time to protect the magnetron. A set or reset arriving inside a hold window is buffered as a pending request and applied when the window expires. A global `force_off` (door open) overrides every channel.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent latch channels (≥1).
- `PRIORITY`, 0: resolution when set and reset are both high in one cycle. 0 = reset-dominant, 1 = set-dominant, 2 = toggle.
- `MIN_ON`, 3: on-hold length in cycles (0 disables the on-hold).
- `MIN_OFF`, 2: off-hold length in cycles (0 disables the off-hold).

Ports:
- `clk`  input  1  sole clock; rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `set`  input  CHANNELS  per-channel set request, sampled each rising edge.
- `reset`  input  CHANNELS  per-channel reset request, sampled each rising edge.
- `force_off`  input  1  synchronous global kill, highest priority.
- `q`  output  CHANNELS  registered latch outputs.
- `hold`  output  CHANNELS  channel's hold counter is non-zero.
- `pending`  output  CHANNELS  channel has a buffered request.

## Operation
- Each channel runs a four-state FSM:
  - OFF_FREE (q=0, cnt=0)
  - ON_HOLD (q=1, cnt≠0)
  - ON_FREE (q=1, cnt=0)
  - OFF_HOLD (q=0, cnt≠0)
- Effective request per edge: resolve `set`/`reset` per PRIORITY.
  - Toggle mode with both high requests the opposite of the current q.
  - A request equal to the current q is a no-op and also clears `pending`.
- FREE states: an opposite request takes effect at that edge.
  - q flips.
  - cnt loads MIN_ON (rising) or MIN_OFF (falling).
  - The FSM enters the HOLD state, or the FREE state if the loaded value is 0.
- HOLD states: an opposite request is stored in `pending` and q is unchanged. The last request wins; a same-state request clears `pending`.
- HOLD to FREE when cnt reaches 0. At the first edge where cnt==0 is sampled:
  - A stored pending request is applied as a fresh transition, which reloads cnt.
  - `pending` clears.
  - A new request at that same edge overrides the pending one.
- `force_off` high at an edge, for all channels:
  - q←0 regardless of MIN_ON.
  - pending←0.
  - cnt←MIN_OFF; channels already at q=0 keep their current cnt.
  - While `force_off` stays high, set requests are discarded and never buffered.
- Counter width is $clog2(max(MIN_ON,MIN_OFF)+1), minimum 1. The counter decrements by 1 per cycle in HOLD and saturates at 0.
- Channels are fully independent apart from `force_off`.

## Timing
- Reset (asynchronous assert, synchronous release): q=0, hold=0, pending=0, all FSMs OFF_FREE.
- Latency: a request sampled at edge k changes q after edge k (1 cycle) when the channel is FREE.
- Minimum high time is MIN_ON+1 cycles; minimum low time is MIN_OFF+1 cycles. The only exceptions are `force_off` and `rst`.
- `hold` and `pending` are registered and change on the same edge as the state they reflect.
- `rst` asserted mid-hold clears everything immediately. No pending request survives reset.
- `force_off` and a set at the same edge: force wins and the set is dropped.

## Structure
- Shared package `magnetron_pkg`:
  - localparams PRIO_RESET=0, PRIO_SET=1, PRIO_TOGGLE=2.
  - channel state enum (OFF_FREE, ON_HOLD, ON_FREE, OFF_HOLD).
- Sub-module `sr_hold_channel`: one channel's FSM, counter and pending bit. The top level is a generate loop of CHANNELS instances plus `force_off` fan-out.
- Target size is about 150–250 lines in total.

## Test plan
All scenarios use CHANNELS=4, MIN_ON=3, MIN_OFF=2 unless stated otherwise.
- Reset state: assert `rst` mid-simulation while q=4'b1111 → q, hold and pending all 0 immediately, without waiting for a clock edge.
- Basic latch: set[0] pulsed at edge 1 → q[0]=1 after edge 1. reset[0] pulsed at edge 6 → q[0]=0 after edge 6.
- On-hold buffering: set[0] at edge 1, reset[0] at edge 2 → pending[0]=1 after edge 2, q[0] falls at edge 5 (4 cycles high), pending[0]=0 after edge 5.
- Priority modes, with set=reset=4'b0001 at one edge on a FREE channel:
  - PRIORITY=0 → q[0]=0.
  - PRIORITY=1 → q[0]=1.
  - PRIORITY=2 → q[0] inverts on every such edge, subject to holds.
- Force-off:
  - Setup: q=4'b0011, with ch0 in ON_HOLD.
  - Stimulus: force_off high for 3 edges while set=4'b1111.
  - Required: q=0 after the first edge; pending=0; q remains 0 throughout.
  - After release: set=4'b1111 → q=4'b1111 after the later of (a) the first edge following release and (b) MIN_OFF expiry.
- Cancel pending: during ON_HOLD, reset[1] then set[1] in consecutive cycles → pending[1] set then cleared. q[1] stays 1 after the hold expires.
